// File: rtl/data_ram_resp.sv
// Data-memory responder for the rv32i load/store port: one request at a time,
// configurable wait states, byte-strobed writes, full-word reads, error flagging.
module data_ram_resp #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  err_pend_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_live;
  logic                  range_err, be_err, err_live;
  logic                  act_we, act_err;
  logic [DEPTH_LOG2-1:0] act_idx;
  logic [31:0]           act_wdata;
  logic [3:0]            act_be;
  logic                  enter_resp, mem_we;

  always_comb begin
    idx_live  = DEPTH_LOG2'((addr_i - BASE_ADDR) >> 2);
    range_err = ({1'b0, addr_i} < {1'b0, BASE_ADDR}) || ({1'b0, addr_i} >= LIMIT);
    case (be_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_err = 1'b0;
      default:                   be_err = 1'b1;
    endcase
    err_live  = range_err | (we_i & be_err);
  end

  // With zero wait states RESP is entered on the grant edge itself, so the
  // array access must use the live request rather than the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      act_we    = we_i;
      act_err   = err_live;
      act_idx   = idx_live;
      act_wdata = wdata_i;
      act_be    = be_i;
    end else begin
      act_we    = we_q;
      act_err   = err_pend_q;
      act_idx   = idx_q;
      act_wdata = wdata_q;
      act_be    = be_q;
    end
    enter_resp = (state_d == ST_RESP) && !rst_i;
    mem_we     = enter_resp && act_we && !act_err;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i && !rst_i) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_o    = (state_q == ST_IDLE) && req_i && !rst_i;
    rvalid_o = (state_q == ST_RESP);
    busy_o   = (state_q != ST_IDLE);
    rdata_o  = rdata_q;
    err_o    = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (gnt_o) begin
      we_q       <= we_i;
      idx_q      <= idx_live;
      wdata_q    <= wdata_i;
      be_q       <= be_i;
      err_pend_q <= err_live;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= act_err;
      rdata_q <= (!act_we && !act_err) ? mem[act_idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (act_be[k]) mem[act_idx][8*k +: 8] <= act_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: doc/data_ram_resp.md
# data_ram_resp

Data-memory responder for the rv32i core's load/store port. It accepts one request at a time over a req/gnt/rvalid handshake and inserts a configurable number of wait states. It performs byte-strobed writes and full-word reads on an internal word array, and flags out-of-range addresses and illegal strobe patterns. It sits on the target side of the core's data-memory interface, opposite the execute/writeback stages that initiate loads and stores.

## Interface
Parameters:
- DEPTH_LOG2, 10: array depth is 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h0000_1000: byte address of word 0; must be 4-byte aligned.
- WAIT_CYCLES, 2: wait states between accept and response; range 0..15.

Ports (one clock; reset is synchronous and active-high):
- clk_i, input, 1: clock; all state updates on its rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- req_i, input, 1: request valid; held by the initiator until granted.
- we_i, input, 1: 1 = write, 0 = read.
- addr_i, input, 32: byte address; bits [1:0] are ignored; the word index is (addr_i-BASE_ADDR)>>2.
- wdata_i, input, 32: write data in lane-aligned form; byte k is wdata_i[8k+7:8k].
- be_i, input, 4: write byte enables; ignored for reads.
- gnt_o, output, 1: request accepted this cycle.
- rvalid_o, output, 1: one-cycle response strobe.
- rdata_o, output, 32: read data, valid while rvalid_o is high.
- err_o, output, 1: access error, valid while rvalid_o is high.
- busy_o, output, 1: a transaction is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - gnt_o = req_i & ~rst_i, combinational.
  - On a granted edge, latch we_i, addr_i, wdata_i and be_i, and compute the error flag.
  - Load cnt with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, else to RESP.
- WAIT:
  - cnt decrements each cycle.
  - When cnt == 1, the next state is RESP.
  - gnt_o = 0.
- Array access happens on the edge that enters RESP:
  - A legal read registers array[index] into rdata_o.
  - A legal write updates only the bytes enabled by be_i.
  - A write response, or any error response, drives rdata_o = 0.
- RESP:
  - rvalid_o = 1 and err_o = latched error flag, for exactly one cycle.
  - Next state is IDLE unconditionally.
  - gnt_o = 0, so the earliest new grant is in the cycle after RESP.
- Error conditions; any error suppresses the array update:
  - addr_i < BASE_ADDR, or addr_i >= BASE_ADDR + 4*2^DEPTH_LOG2, computed with a 33-bit compare with no wrap.
  - A write whose be_i is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Read data is never forwarded from an in-flight write. Only one transaction exists at a time, so no hazard arises.
- Array contents are not cleared by reset. Simulation initial contents are don't-care.

## Timing
- Reset values: state IDLE, cnt 0, gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0, busy_o 0.
- Latency: if the grant occurs in cycle N, rvalid_o is high in cycle N+1+WAIT_CYCLES.
- Back-to-back throughput: one transaction per WAIT_CYCLES+2 cycles when req_i is held continuously.
- rdata_o and err_o hold their value after RESP until the next response. The initiator samples them only while rvalid_o is high.
- Inputs only need to be stable in the grant cycle. Changes after the grant are ignored.
- Reset mid-operation (in WAIT or RESP):
  - The next state is IDLE, and the pending transaction is dropped.
  - No array write occurs, including when reset coincides with the edge that would enter RESP.
  - rvalid_o is 0 in the cycle after reset.
- If req_i is high during reset, no grant is issued until the first cycle with rst_i low.

## Test plan
- Full-word write, then read back (WAIT_CYCLES=2, BASE_ADDR=0x1000):
  - Write 0xDEADBEEF, be=1111, to 0x1004, granted in cycle 0 -> rvalid_o in cycle 3, err_o=0.
  - Read 0x1004 -> rdata_o=0xDEADBEEF.
- Byte write: be=0010, wdata=0x0000AA00 to 0x1004 -> a subsequent read returns 0xDEADAAEF.
- Out of range:
  - Read 0x2000 -> rvalid_o with err_o=1 and rdata_o=0.
  - Read 0x0FFC -> err_o=1.
  - Read 0x1FFC -> err_o=0.
- Illegal strobe: write with be=0101 -> err_o=1. A read of the same word is unchanged.
- Throughput: req_i held high with 3 queued reads -> gnt_o in cycles 0, 4 and 8; rvalid_o in cycles 3, 7 and 11. With WAIT_CYCLES=0, rvalid_o comes 1 cycle after each grant.
- Reset in WAIT: write 0x12345678 to 0x1008 and assert rst_i one cycle after the grant -> no rvalid_o, busy_o=0 in the following cycle, and a read of 0x1008 returns the prior value.
